// File: rtl/histo_readout_if.sv
// Byte link from the histogram readout to the serializer.
// master drives data/valid, slave answers with ready.
interface histo_readout_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/histo_readout.sv
// Frame readout of per-channel histograms: header, NCHAN x NHIST words MSB-first, XOR trailer,
// optional one-cycle histogram clear afterwards.
module histo_readout #(
    parameter int NCHAN  = 16,
    parameter int NHIST  = 8,
    parameter int SETTLE = 2
) (
    input  logic               clk_adc,
    input  logic               rst,
    input  logic               start,
    input  logic               clear_after,
    input  logic [NHIST*32-1:0] histosout,
    output logic [7:0]         histostosend,
    output logic               resethist,
    output logic               busy,
    histo_readout_if.master    tx
);

    localparam int          WW          = (NHIST > 1) ? $clog2(NHIST) : 1;
    localparam logic [7:0]  LAST_CH     = 8'(NCHAN - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(NHIST - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [7:0]  HEADER_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SELECT,
        S_CAPTURE,
        S_SEND,
        S_TRAILER,
        S_CLEAR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]              ch_idx;
    logic [WW-1:0]           word_idx;
    logic [1:0]              byte_idx;
    logic [3:0]              settle_cnt;
    logic [7:0]              checksum;
    logic                    clr_lat;
    logic [NHIST-1:0][31:0]  hbuf;

    logic [31:0] cur_word;
    logic [7:0]  send_byte;
    logic        xfer;
    logic        last_byte;
    logic        last_ch;

    assign xfer      = tx.tx_valid && tx.tx_ready;
    assign last_byte = (byte_idx == 2'd3) && (word_idx == LAST_WORD);
    assign last_ch   = (ch_idx == LAST_CH);

    // Current payload byte, most-significant byte of the word first.
    always_comb begin
        cur_word  = hbuf[word_idx];
        send_byte = '0;
        case (byte_idx)
            2'd0:    send_byte = cur_word[31:24];
            2'd1:    send_byte = cur_word[23:16];
            2'd2:    send_byte = cur_word[15:8];
            default: send_byte = cur_word[7:0];
        endcase
    end

    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_HEADER;
            S_HEADER:  if (xfer) state_nxt = S_SELECT;
            S_SELECT:  if (settle_cnt == SETTLE_LAST) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_SEND;
            S_SEND: begin
                if (xfer && last_byte) begin
                    state_nxt = last_ch ? S_TRAILER : S_SELECT;
                end
            end
            S_TRAILER: if (xfer) state_nxt = clr_lat ? S_CLEAR : S_IDLE;
            S_CLEAR:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = '0;
        resethist   = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_HEADER: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = HEADER_BYTE;
            end
            S_SEND: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = send_byte;
            end
            S_TRAILER: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = checksum;
            end
            S_CLEAR: resethist = 1'b1;
            default: ;
        endcase
    end

    // histostosend is only loaded on the edges that enter SELECT, so it holds elsewhere.
    always_ff @(posedge clk_adc or posedge rst) begin
        if (rst) begin
            ch_idx       <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            settle_cnt   <= '0;
            checksum     <= '0;
            clr_lat      <= 1'b0;
            histostosend <= '0;
            hbuf         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        clr_lat    <= clear_after;
                        checksum   <= '0;
                        ch_idx     <= '0;
                        word_idx   <= '0;
                        byte_idx   <= '0;
                        settle_cnt <= '0;
                    end
                end
                S_HEADER: begin
                    if (xfer) begin
                        ch_idx       <= '0;
                        histostosend <= '0;
                        settle_cnt   <= '0;
                    end
                end
                S_SELECT: settle_cnt <= settle_cnt + 4'd1;
                S_CAPTURE: begin
                    hbuf     <= histosout;
                    word_idx <= '0;
                    byte_idx <= '0;
                end
                S_SEND: begin
                    if (xfer) begin
                        checksum <= checksum ^ send_byte;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            word_idx <= (word_idx == LAST_WORD) ? '0 : word_idx + 1'b1;
                        end
                        if (last_byte && !last_ch) begin
                            ch_idx       <= ch_idx + 8'd1;
                            histostosend <= ch_idx + 8'd1;
                            settle_cnt   <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/histo_readout.md
HISTO_READOUT -- requirements
Module: histo_readout

Interface
REQ-001 Parameter NCHAN, default 16, number of trigger channels scanned per frame.
REQ-002 Parameter NHIST, default 8, histogram words per channel.
REQ-003 Parameter SETTLE, default 2, clk_adc cycles between changing histostosend and capturing histosout (1..15).
REQ-004 clk_adc  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to read out one frame; ignored unless idle.
REQ-007 clear_after  input  1  sampled with accepted start; when 1, clear histograms after the frame.
REQ-008 histosout  input  NHIST*32  histogram words for the selected channel; word k at bits [32k+31:32k].
REQ-009 histostosend  output  8  channel select driven to the histogram block.
REQ-010 resethist  output  1  one-cycle histogram clear pulse.
REQ-011 tx_data  output  8  byte to the link serializer.
REQ-012 tx_valid  output  1  tx_data holds a valid byte.
REQ-013 tx_ready  input  1  serializer accepts the byte this cycle when tx_valid=1.
REQ-014 busy  output  1  high from accepted start until return to IDLE.

Function
REQ-015 States SHALL be IDLE, HEADER, SELECT, CAPTURE, SEND, TRAILER, CLEAR.
REQ-016 IDLE->HEADER on start=1; latch clear_after; zero checksum, channel index, word index, byte index.
REQ-017 HEADER SHALL present tx_data=0xA5, tx_valid=1; on tx_ready go to SELECT with channel index 0.
REQ-018 SELECT SHALL drive histostosend=channel index and wait exactly SETTLE cycles, then go to CAPTURE.
REQ-019 CAPTURE SHALL latch all NHIST words of histosout into a local buffer in one cycle, then go to SEND.
REQ-020 SEND SHALL emit words 0..NHIST-1 in order, each as 4 bytes most-significant first: NHIST*4 bytes per channel.
REQ-021 A byte counts as transferred only on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-022 tx_valid SHALL stay high between bytes within HEADER/SEND/TRAILER (back-to-back transfer permitted at one byte per cycle when tx_ready held 1).
REQ-023 After the last byte of a channel: if channel index < NCHAN-1, increment and go to SELECT; otherwise go to TRAILER.
REQ-024 Checksum SHALL be the 8-bit XOR of all payload bytes (excluding header) transferred in SEND.
REQ-025 TRAILER SHALL present tx_data=checksum; on transfer go to CLEAR if latched clear_after=1, else IDLE.
REQ-026 CLEAR SHALL assert resethist for exactly one cycle, then go to IDLE.
REQ-027 tx_valid SHALL be 0 in IDLE, SELECT, CAPTURE, CLEAR.
REQ-028 histostosend SHALL hold its last value outside SELECT/CAPTURE/SEND; it changes only on entry to SELECT.
REQ-029 start asserted while busy=1 SHALL be ignored and not queued.
REQ-030 Channel index width 8 bits; NCHAN>256 unsupported; no wrap within a frame.
REQ-031 Buffered words SHALL not change during SEND even if histosout changes.
REQ-032 Frame length SHALL be 1 + NCHAN*NHIST*4 + 1 bytes (514 at defaults).
REQ-033 busy SHALL deassert on the cycle the state returns to IDLE.

Reset
REQ-034 rst=1 SHALL asynchronously force state IDLE, histostosend=0, tx_data=0, tx_valid=0, resethist=0, busy=0, checksum=0, all indices 0.
REQ-035 rst asserted mid-frame SHALL abort the frame with no trailer and no resethist pulse; a new start after rst release begins a fresh frame with header.

Verification
REQ-036 tx_ready=1 constant, histosout word k = {ch,k} pattern, start -> 514 bytes: 0xA5, bytes in channel/word/MSB order, correct XOR trailer; busy high ~514+16*(SETTLE+1) cycles.
REQ-037 Random tx_ready backpressure -> byte stream identical to REQ-036; tx_data never changes while tx_valid=1 and tx_ready=0.
REQ-038 histosout changed every cycle during SEND -> transmitted words equal values present at CAPTURE cycle, SETTLE cycles after histostosend update.
REQ-039 start with clear_after=1 -> single resethist pulse exactly one cycle after trailer transfer; clear_after=0 -> no pulse.
REQ-040 start pulsed repeatedly during a frame -> exactly one frame sent.
REQ-041 rst asserted during channel 5 SEND -> all outputs 0 immediately; next start yields full correct frame.
